// File: rtl/receiver_pkg.sv
// Shared frame constants and state encodings for the serial link.
// The transmitter imports these so both ends agree on the frame layout.
package receiver_pkg;

  localparam int DATA_BITS = 7;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA    = 3'd1,
    PARITY  = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  function automatic logic is_start(input logic b);
    return b == START_LEVEL;
  endfunction

  function automatic logic is_stop(input logic b);
    return b == STOP_LEVEL;
  endfunction

endpackage

// File: rtl/receiver.sv
// Serial frame receiver: start, 7 data bits LSB first, even parity, stop.
// One bit per clock; result and error flags are one-cycle pulses.
module receiver
  import receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       serial_in,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  state_t state;
  state_t state_nxt;

  logic [2:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic par_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (is_start(serial_in)) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
          state_nxt = PARITY;
        end
      end
      PARITY: begin
        state_nxt = STOP;
      end
      STOP: begin
        state_nxt = is_stop(serial_in) ? IDLE : RECOVER;
      end
      RECOVER: begin
        // a low line here is a broken frame, not a new start bit
        if (is_stop(serial_in)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (is_start(serial_in)) begin
            bit_cnt <= '0;
            par_acc <= 1'b0;
          end
        end
        DATA: begin
          shreg[bit_cnt] <= serial_in;
          par_acc <= par_acc ^ serial_in;
          bit_cnt <= (bit_cnt == LAST_BIT) ? 3'd0 : bit_cnt + 3'd1;
        end
        PARITY: begin
          // accumulator now holds data parity xor received parity bit
          par_acc <= par_acc ^ serial_in;
        end
        STOP: begin
          data_out   <= shreg;
          parity_err <= par_acc;
          frame_err  <= !is_stop(serial_in);
          data_valid <= !par_acc && is_stop(serial_in);
        end
        RECOVER: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed frames plus random traffic,
// with expectations computed per frame from the frame contents.
module tb_receiver;

  logic       clk;
  logic       rstn;
  logic       serial_in;
  logic [6:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int compared;
  int mismatched;
  int valid_pulses;

  logic [6:0] exp_data;

  receiver dut (
    .clk        (clk),
    .rstn       (rstn),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (data_valid === 1'b1) valid_pulses++;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v,
                         input logic pe, input logic fe,
                         input logic bz);
    chk({tag, ".data_out"}, {1'b0, data_out}, {1'b0, exp_data});
    chk({tag, ".valid"}, {7'd0, data_valid}, {7'd0, v});
    chk({tag, ".parity_err"}, {7'd0, parity_err}, {7'd0, pe});
    chk({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, fe});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, bz});
  endtask

  // drive one line bit, let one edge pass, check the result
  task automatic step(input string tag, input logic b, input logic v,
                      input logic pe, input logic fe, input logic bz);
    @(negedge clk);
    serial_in = b;
    @(posedge clk);
    #1;
    chk_all(tag, v, pe, fe, bz);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b1, 0, 0, 0, 0);
  endtask

  // recovery: line held low n cycles then one high sample
  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) step("low", 1'b0, 0, 0, 0, 1);
    step("release", 1'b1, 0, 0, 0, 0);
  endtask

  task automatic send_frame(input string tag, input logic [6:0] d,
                            input logic pbit, input logic sbit);
    logic pe;
    logic fe;
    pe = logic'($countones(d) % 2) ^ pbit;
    fe = !sbit;
    step({tag, ".start"}, 1'b0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step({tag, ".data"}, d[i], 0, 0, 0, 1);
    end
    step({tag, ".parity"}, pbit, 0, 0, 0, 1);
    exp_data = d;
    step({tag, ".stop"}, sbit, !pe && !fe, pe, fe, !sbit);
  endtask

  function automatic logic even_par(input logic [6:0] d);
    return logic'($countones(d) % 2);
  endfunction

  initial begin
    logic [6:0] d;
    logic pb;
    logic sb;
    int vp;
    compared = 0;
    mismatched = 0;
    valid_pulses = 0;
    exp_data = '0;
    rstn = 1'b0;
    serial_in = 1'b1;
    #2;
    chk_all("reset", 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_hold", 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    send_frame("f55", 7'h55, 1'b0, 1'b1);
    idle(1);

    send_frame("f7f", 7'h7F, 1'b1, 1'b1);
    send_frame("f12", 7'h12, 1'b0, 1'b1);
    idle(2);

    send_frame("perr01", 7'h01, 1'b0, 1'b1);
    idle(1);

    send_frame("ferr2a", 7'h2A, even_par(7'h2A), 1'b0);
    hold_low(5);
    send_frame("f33", 7'h33, even_par(7'h33), 1'b1);

    send_frame("both", 7'h0F, 1'b1, 1'b0);
    hold_low(1);

    // abort 7'h6B after three data bits
    step("abort.start", 1'b0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step("abort.data", logic'(7'h6B >> i), 0, 0, 0, 1);
    end
    @(negedge clk);
    rstn = 1'b0;
    serial_in = 1'b0;
    #1;
    exp_data = '0;
    chk_all("abort.reset", 0, 0, 0, 0);
    repeat (8) begin
      @(posedge clk);
      #1;
      chk_all("abort.held", 0, 0, 0, 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    serial_in = 1'b1;
    #1;
    chk_all("abort.release", 0, 0, 0, 0);
    send_frame("post_rst", 7'h33, even_par(7'h33), 1'b1);

    // transmitter-style frames: one valid pulse per start
    vp = valid_pulses;
    send_frame("tx00", 7'h00, even_par(7'h00), 1'b1);
    send_frame("tx7f", 7'h7F, even_par(7'h7F), 1'b1);
    idle(1);
    chk("tx.pulses", 8'(valid_pulses - vp), 8'd2);

    for (int n = 0; n < 60; n++) begin
      d = 7'($urandom_range(0, 127));
      pb = even_par(d) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) != 0);
      send_frame("rnd", d, pb, sb);
      if (!sb) hold_low($urandom_range(0, 3));
      else idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
